// File: rtl/bldc_seq_pkg.sv
// Shared types and constants for the BLDC start-up sequencer.
// Includes the FSM state codes, the bldc mode values, the fault codes and a 17->16 bit saturation helper.
package bldc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ALIGN    = 3'd1,
    ST_RAMP     = 3'd2,
    ST_HANDOFF  = 3'd3,
    ST_RUN      = 3'd4,
    ST_STOPPING = 3'd5,
    ST_FAULT    = 3'd6
  } seq_state_e;

  localparam logic [7:0] MODE_CLOSED = 8'd0;
  localparam logic [7:0] MODE_OPEN   = 8'd1;

  localparam logic [1:0] FAULT_NONE  = 2'd0;
  localparam logic [1:0] FAULT_EXT   = 2'd1;
  localparam logic [1:0] FAULT_STALL = 2'd2;

  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767) begin
      return 16'sh7fff;
    end else if (v < -17'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/bldc_vel_slew.sv
// Tick prescaler plus saturating step-toward-target for the sequencer velocity.
// The prescaler restarts on every state entry, so the first tick comes DIV clocks later.
module bldc_vel_slew
  import bldc_seq_pkg::*;
#(
  parameter int unsigned        DIV  = 64,
  parameter logic signed [15:0] STEP = 16'sd4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               restart_i,
  input  logic signed [15:0] cur_i,
  input  logic signed [15:0] tgt_i,
  output logic               tick_o,
  output logic signed [15:0] next_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;

  // On the first cycle of a state the stale count is treated as zero.
  always_comb begin
    cnt_cur = restart_i ? '0 : cnt_q;
    tick_o  = en_i && (cnt_cur == CNT_LAST);
    cnt_d   = (!en_i || tick_o) ? '0 : cnt_cur + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  logic signed [16:0] cur_x, tgt_x, step_x, up_x, dn_x, res_x;

  always_comb begin
    cur_x  = {cur_i[15], cur_i};
    tgt_x  = {tgt_i[15], tgt_i};
    step_x = {STEP[15], STEP};
    up_x   = cur_x + step_x;
    dn_x   = cur_x - step_x;
    if (cur_x < tgt_x) begin
      res_x = (up_x > tgt_x) ? tgt_x : up_x;
    end else if (cur_x > tgt_x) begin
      res_x = (dn_x < tgt_x) ? tgt_x : dn_x;
    end else begin
      res_x = tgt_x;
    end
    next_o = sat16(res_x);
  end

endmodule

// File: rtl/bldc_startup_seq.sv
// BLDC start-up sequencer: align, open-loop ramp, closed-loop handoff, run, stop, fault.
// Optional stall detection in RUN is built when BLDC_SEQ_STALL_DETECT_EN is defined.
module bldc_startup_seq
  import bldc_seq_pkg::*;
#(
  parameter int unsigned        ALIGN_CYCLES   = 1000,
  parameter logic signed [15:0] ALIGN_VEL      = 16'sd40,
  parameter logic signed [15:0] HANDOFF_VEL    = 16'sd400,
  parameter int unsigned        RAMP_DIV       = 64,
  parameter logic signed [15:0] RAMP_STEP      = 16'sd4,
  parameter logic signed [7:0]  HANDOFF_OFFSET = 8'sd0,
  parameter int unsigned        STALL_CYCLES   = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               fault_in,
  input  logic               clear_fault,
  input  logic signed [15:0] target_velocity,
  input  logic [11:0]        feedback,
  output logic signed [15:0] velocity,
  output logic signed [7:0]  offset,
  output logic               enable,
  output logic [7:0]         mode,
  output logic [2:0]         state,
  output logic [1:0]         fault_code
);

  localparam int ALIGN_W = (ALIGN_CYCLES > 1) ? $clog2(ALIGN_CYCLES) : 1;
  localparam logic [ALIGN_W-1:0] ALIGN_LAST = ALIGN_W'(ALIGN_CYCLES - 1);

  seq_state_e          state_q, prev_state_q;
  logic                dir_neg_q;
  logic signed [15:0]  vel_q;
  logic signed [7:0]   off_q;
  logic                en_q;
  logic [7:0]          mode_q;
  logic [1:0]          fc_q;
  logic [ALIGN_W-1:0]  align_cnt_q;

  logic               slew_en, slew_restart, slew_tick;
  logic signed [15:0] slew_tgt, slew_next, handoff_vel_s;
  logic               tgt_reverse, stall_hit;

  assign handoff_vel_s = dir_neg_q ? -HANDOFF_VEL : HANDOFF_VEL;
  assign tgt_reverse   = (target_velocity == '0) || (target_velocity[15] != dir_neg_q);
  assign slew_en       = (state_q == ST_RAMP) || (state_q == ST_RUN) || (state_q == ST_STOPPING);
  assign slew_restart  = (state_q != prev_state_q);

  always_comb begin
    case (state_q)
      ST_RAMP: slew_tgt = handoff_vel_s;
      ST_RUN:  slew_tgt = target_velocity;
      default: slew_tgt = '0;
    endcase
  end

  bldc_vel_slew #(
    .DIV  (RAMP_DIV),
    .STEP (RAMP_STEP)
  ) u_slew (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (slew_en),
    .restart_i (slew_restart),
    .cur_i     (vel_q),
    .tgt_i     (slew_tgt),
    .tick_o    (slew_tick),
    .next_o    (slew_next)
  );

`ifdef BLDC_SEQ_STALL_DETECT_EN
  localparam logic [31:0] STALL_LAST = 32'(STALL_CYCLES - 1);

  logic [11:0] fb_prev_q;
  logic [31:0] stall_cnt_q;
  logic        fb_same;

  assign fb_same   = (feedback == fb_prev_q);
  assign stall_hit = (state_q == ST_RUN) && fb_same && (stall_cnt_q == STALL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_prev_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fb_prev_q <= feedback;
      if (fault_in || (state_q != ST_RUN) || !fb_same) begin
        stall_cnt_q <= '0;
      end else begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end
`else
  logic unused_stall;
  assign stall_hit    = 1'b0;
  assign unused_stall = ^{feedback, 32'(STALL_CYCLES)};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      prev_state_q <= ST_IDLE;
      dir_neg_q    <= 1'b0;
      vel_q        <= '0;
      off_q        <= '0;
      en_q         <= 1'b0;
      mode_q       <= MODE_OPEN;
      fc_q         <= FAULT_NONE;
      align_cnt_q  <= '0;
    end else begin
      prev_state_q <= state_q;
      // External fault overrides every other request.
      if (fault_in) begin
        state_q <= ST_FAULT;
        vel_q   <= '0;
        off_q   <= '0;
        en_q    <= 1'b0;
        mode_q  <= MODE_OPEN;
        fc_q    <= FAULT_EXT;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start && !stop && (target_velocity != '0)) begin
              state_q     <= ST_ALIGN;
              dir_neg_q   <= target_velocity[15];
              vel_q       <= target_velocity[15] ? -ALIGN_VEL : ALIGN_VEL;
              en_q        <= 1'b1;
              mode_q      <= MODE_OPEN;
              align_cnt_q <= '0;
            end
          end
          ST_ALIGN: begin
            if (stop) begin
              state_q <= ST_STOPPING;
            end else if (align_cnt_q == ALIGN_LAST) begin
              state_q <= ST_RAMP;
            end else begin
              align_cnt_q <= align_cnt_q + ALIGN_W'(1);
            end
          end
          ST_RAMP: begin
            if (stop) begin
              state_q <= ST_STOPPING;
            end else if (slew_tick) begin
              vel_q <= slew_next;
              if (slew_next == handoff_vel_s) begin
                state_q <= ST_HANDOFF;
                mode_q  <= MODE_CLOSED;
                off_q   <= HANDOFF_OFFSET;
              end
            end
          end
          ST_HANDOFF: begin
            state_q <= stop ? ST_STOPPING : ST_RUN;
          end
          ST_RUN: begin
            if (stall_hit) begin
              state_q <= ST_FAULT;
              vel_q   <= '0;
              off_q   <= '0;
              en_q    <= 1'b0;
              mode_q  <= MODE_OPEN;
              fc_q    <= FAULT_STALL;
            end else if (stop || tgt_reverse) begin
              state_q <= ST_STOPPING;
            end else if (slew_tick) begin
              vel_q <= slew_next;
            end
          end
          ST_STOPPING: begin
            if ((vel_q == '0) || (slew_tick && (slew_next == '0))) begin
              state_q <= ST_IDLE;
              vel_q   <= '0;
              off_q   <= '0;
              en_q    <= 1'b0;
              mode_q  <= MODE_OPEN;
            end else if (slew_tick) begin
              vel_q <= slew_next;
            end
          end
          ST_FAULT: begin
            if (clear_fault) begin
              state_q <= ST_IDLE;
              fc_q    <= FAULT_NONE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign velocity   = vel_q;
  assign offset     = off_q;
  assign enable     = en_q;
  assign mode       = mode_q;
  assign state      = state_q;
  assign fault_code = fc_q;

endmodule
